// File: rtl/dsc_mul_sched.sv
// Two-requester round-robin front end for one shared 3-input serial
// stochastic multiplier. Operands are latched, the multiplier is cleared and
// then run until it flags done (or a run-length limit expires), and a tagged
// result is returned over a valid/ready response port.
module dsc_mul_sched #(
  parameter int unsigned NUM_BITS = 6,
  parameter int unsigned RES_W    = 18,
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned SETTLE   = 1,
  parameter int unsigned TIMEOUT  = 262200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [3*NUM_BITS-1:0] req0_ops_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [3*NUM_BITS-1:0] req1_ops_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_id_o,
  output logic [RES_W-1:0]      rsp_z_o,
  output logic [CNT_W-1:0]      rsp_cycles_o,
  output logic                  rsp_timeout_o,
  output logic                  busy_o,
  output logic                  mul_rst_o,
  output logic                  mul_en_o,
  output logic [NUM_BITS-1:0]   mul_a_o,
  output logic [NUM_BITS-1:0]   mul_b_o,
  output logic [NUM_BITS-1:0]   mul_c_o,
  input  logic [RES_W-1:0]      mul_z_i,
  input  logic                  mul_ov_i
);

  localparam int unsigned OPS_W = 3 * NUM_BITS;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic                mul_rst_q, mul_rst_d;
  logic                mul_en_q, mul_en_d;
  logic [NUM_BITS-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_c_q, mul_c_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]    rsp_z_q, rsp_z_d;
  logic [CNT_W-1:0]    rsp_cycles_q, rsp_cycles_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                busy_q, busy_d;

  logic                grant;
  logic                accept;
  logic [OPS_W-1:0]    ops;
  logic [CNT_W-1:0]    cnt_inc;

  // Round-robin grant: a lone requester wins, on contention the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) grant = ~last_grant_q;
    else if (req1_valid_i)            grant = 1'b1;
  end

  assign req0_ready_o = !rst && (state_q == S_IDLE) && req0_valid_i && !grant;
  assign req1_ready_o = !rst && (state_q == S_IDLE) && req1_valid_i &&  grant;
  assign accept       = req0_ready_o || req1_ready_o;
  assign ops          = grant ? req1_ops_i : req0_ops_i;
  assign cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    set_d         = set_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    mul_c_d       = mul_c_q;
    rsp_id_d      = rsp_id_q;
    rsp_z_d       = rsp_z_q;
    rsp_cycles_d  = rsp_cycles_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mul_a_d      = ops[OPS_W-1 -: NUM_BITS];
          mul_b_d      = ops[2*NUM_BITS-1 -: NUM_BITS];
          mul_c_d      = ops[NUM_BITS-1:0];
          id_d         = grant;
          last_grant_d = grant;
          cnt_d        = '0;
          state_d      = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        cnt_d = cnt_inc;
        if (mul_ov_i) begin
          set_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          rsp_id_d      = id_q;
          rsp_z_d       = '0;
          rsp_cycles_d  = cnt_inc;
          rsp_timeout_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_SETTLE: begin
        if (set_q == SET_W'(SETTLE - 1)) begin
          rsp_id_d      = id_q;
          rsp_z_d       = mul_z_i;
          rsp_cycles_d  = cnt_q;
          rsp_timeout_d = 1'b0;
          state_d       = S_DONE;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Multiplier controls and status follow the state being entered.
    mul_en_d    = (state_d == S_RUN);
    mul_rst_d   = !((state_d == S_RUN) || (state_d == S_SETTLE));
    rsp_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset discards any in-flight job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      id_q          <= 1'b0;
      cnt_q         <= '0;
      set_q         <= '0;
      mul_rst_q     <= 1'b1;
      mul_en_q      <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_c_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_z_q       <= '0;
      rsp_cycles_q  <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      set_q         <= set_d;
      mul_rst_q     <= mul_rst_d;
      mul_en_q      <= mul_en_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_c_q       <= mul_c_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_z_q       <= rsp_z_d;
      rsp_cycles_q  <= rsp_cycles_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign mul_rst_o     = mul_rst_q;
  assign mul_en_o      = mul_en_q;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;
  assign mul_c_o       = mul_c_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_z_o       = rsp_z_q;
  assign rsp_cycles_o  = rsp_cycles_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign busy_o        = busy_q;

endmodule
